// File: rtl/sat_updown_counter_pkg.sv
// Shared definitions for the saturating up/down counter and the timer
// blocks that reuse its state encoding.
package sat_updown_counter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HELD = 2'b10
    } cnt_state_t;

endpackage

// File: rtl/sat_updown_counter.sv
// Up/down counter with a programmable upper limit. It either saturates at
// the limits (RECYCLE=0) or wraps around (RECYCLE=1). A small FSM tracks
// idle / running / held-at-limit, and done pulses for one cycle when a
// limit is reached (saturating) or the count wraps (recycling).
module sat_updown_counter
    import sat_updown_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 2**WIDTH - 1,
    parameter bit RECYCLE   = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               up_down,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    output logic [WIDTH-1:0]   count,
    output logic               terminal,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             at_limit;

    // Limit that the count runs towards in the given direction.
    function automatic logic [WIDTH-1:0] limit_of(input logic dir);
        return dir ? MAX_C : '0;
    endfunction

    // Loaded values above the limit are clipped to the limit.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_C) ? MAX_C : v;
    endfunction

    // One step in the given direction; callers guarantee no limit is crossed.
    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                    input logic             dir);
        return dir ? (c + ONE_C) : (c - ONE_C);
    endfunction

    assign at_limit = (count_q == limit_of(up_down));

    // Next count, next state and next done: load beats enable; a step that
    // would cross a limit either saturates (entering HELD) or wraps.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN, ST_HELD: begin
                if (load) begin
                    count_d = clamp_load(load_value);
                    if (!RECYCLE && (clamp_load(load_value) == limit_of(up_down)))
                        state_d = ST_HELD;
                    else
                        state_d = ST_RUN;
                end else if (enable) begin
                    if (at_limit) begin
                        if (RECYCLE) begin
                            count_d = limit_of(!up_down);
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else if (state_q != ST_HELD) begin
                            // Pushing against the limit from RUN/IDLE parks here.
                            state_d = ST_HELD;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = step_count(count_q, up_down);
                        state_d = ST_RUN;
                        if (!RECYCLE && (step_count(count_q, up_down) == limit_of(up_down))) begin
                            state_d = ST_HELD;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                // Unused encoding: fall back to IDLE without touching the count.
                state_d = ST_IDLE;
            end
        endcase
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Done pulse register, aligned with the count edge it reports.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            done_q <= 1'b0;
        else
            done_q <= done_d;
    end

    assign count    = count_q;
    assign state    = state_q;
    assign done     = done_q;
    assign terminal = at_limit;

endmodule

// File: tb/tb_sat_updown_counter.sv
// Bench for sat_updown_counter: three configurations share one stimulus
// stream and are compared against a plain-integer reference model.
module tb_sat_updown_counter;

    localparam int N = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       up_down = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] cnt_o  [N];
    logic       term_o [N];
    logic       done_o [N];
    logic [1:0] st_o   [N];

    int m_cnt  [N];
    int m_st   [N];
    int m_done [N];

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    sat_updown_counter #(.WIDTH(4), .MAX_VALUE(15), .RECYCLE(1'b0)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value),
        .count(cnt_o[0]), .terminal(term_o[0]), .done(done_o[0]), .state(st_o[0]));

    sat_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .RECYCLE(1'b1)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value),
        .count(cnt_o[1]), .terminal(term_o[1]), .done(done_o[1]), .state(st_o[1]));

    sat_updown_counter #(.WIDTH(4), .MAX_VALUE(11), .RECYCLE(1'b0)) dut_c (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value),
        .count(cnt_o[2]), .terminal(term_o[2]), .done(done_o[2]), .state(st_o[2]));

    function automatic int maxv(input int i);
        case (i)
            0: return 15;
            1: return 9;
            default: return 11;
        endcase
    endfunction

    function automatic bit recyc(input int i);
        return (i == 1);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i]  = 0;
            m_st[i]   = 0;
            m_done[i] = 0;
        end
    endtask

    // Reference behaviour for one rising edge, from the counting rules.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int mx, lim, v, target;
            mx  = maxv(i);
            lim = up_down ? mx : 0;
            m_done[i] = 0;
            if (load) begin
                v = (int'(load_value) < mx) ? int'(load_value) : mx;
                m_cnt[i] = v;
                m_st[i]  = (!recyc(i) && v == lim) ? 2 : 1;
            end else if (enable) begin
                target = up_down ? m_cnt[i] + 1 : m_cnt[i] - 1;
                if (recyc(i)) begin
                    if (target > mx) begin
                        target = 0;
                        m_done[i] = 1;
                    end else if (target < 0) begin
                        target = mx;
                        m_done[i] = 1;
                    end
                    m_cnt[i] = target;
                    m_st[i]  = 1;
                end else if (target > mx || target < 0) begin
                    if (m_st[i] != 2) begin
                        m_st[i]   = 2;
                        m_done[i] = 1;
                    end
                end else begin
                    m_cnt[i] = target;
                    if (target == lim) begin
                        m_st[i]   = 2;
                        m_done[i] = 1;
                    end else begin
                        m_st[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            int exp_term;
            exp_term = up_down ? int'(m_cnt[i] == maxv(i)) : int'(m_cnt[i] == 0);
            chk($sformatf("%s.count[%0d]", tag, i), int'(cnt_o[i]), m_cnt[i]);
            chk($sformatf("%s.state[%0d]", tag, i), int'(st_o[i]), m_st[i]);
            chk($sformatf("%s.done[%0d]", tag, i), int'(done_o[i]), m_done[i]);
            chk($sformatf("%s.terminal[%0d]", tag, i), int'(term_o[i]), exp_term);
        end
    endtask

    // Advance one clock, update the model, then sample 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clock);
        if (!reset) model_reset();
        else        model_edge();
        #1;
        check_all(tag);
    endtask

    // Drop reset between edges and confirm the asynchronous clear.
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
    endtask

    initial begin
        int pulses;

        // Reset state, asynchronous, before any clock edge.
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        chk("rst.count", int'(cnt_o[0]), 0);
        chk("rst.state", int'(st_o[0]), 0);
        chk("rst.term_down", int'(term_o[0]), 1);
        up_down = 1'b1;
        #1;
        chk("rst.term_up", int'(term_o[0]), 0);
        tick("rst_clk");

        // First edge after release with nothing requested: stay idle.
        reset = 1'b1;
        tick("idle_hold");
        chk("idle.state", int'(st_o[0]), 0);

        // Count up 20 cycles: saturate at 15, single done pulse.
        up_down = 1'b1;
        enable  = 1'b1;
        pulses  = 0;
        for (int k = 0; k < 20; k++) begin
            tick("up20");
            if (done_o[0]) begin
                pulses++;
                chk("up20.done_at", int'(cnt_o[0]), 15);
            end
        end
        chk("up20.pulses", pulses, 1);
        chk("up20.final_count", int'(cnt_o[0]), 15);
        chk("up20.final_state", int'(st_o[0]), 2);

        // Reverse direction out of HELD.
        up_down = 1'b0;
        tick("leave_held");
        chk("leave.count", int'(cnt_o[0]), 14);
        chk("leave.state", int'(st_o[0]), 1);
        chk("leave.term", int'(term_o[0]), 0);

        // Load beats enable and clamps to the limit.
        up_down    = 1'b1;
        load       = 1'b1;
        load_value = 4'd13;
        tick("load_clamp");
        chk("clamp.count", int'(cnt_o[2]), 11);
        chk("clamp.state", int'(st_o[2]), 2);
        chk("clamp.count_a", int'(cnt_o[0]), 13);

        // Recycling counter wraps 9 -> 0 with a done pulse.
        enable     = 1'b0;
        load_value = 4'd8;
        tick("load8");
        load   = 1'b0;
        enable = 1'b1;
        tick("wrap_9");
        chk("wrap.count9", int'(cnt_o[1]), 9);
        chk("wrap.done9", int'(done_o[1]), 0);
        tick("wrap_0");
        chk("wrap.count0", int'(cnt_o[1]), 0);
        chk("wrap.done0", int'(done_o[1]), 1);
        chk("wrap.state", int'(st_o[1]), 1);

        // Down from 2 saturates at 0.
        up_down    = 1'b0;
        load       = 1'b1;
        enable     = 1'b0;
        load_value = 4'd2;
        tick("load2");
        load   = 1'b0;
        enable = 1'b1;
        tick("down1");
        chk("down.count1", int'(cnt_o[0]), 1);
        tick("down0");
        chk("down.count0", int'(cnt_o[0]), 0);
        chk("down.done0", int'(done_o[0]), 1);
        tick("down_hold");
        chk("down.hold_count", int'(cnt_o[0]), 0);
        chk("down.hold_done", int'(done_o[0]), 0);
        chk("down.hold_term", int'(term_o[0]), 1);

        // Asynchronous reset mid-count aborts with no done pulse.
        up_down    = 1'b1;
        load       = 1'b1;
        load_value = 4'd6;
        tick("load6");
        load = 1'b0;
        async_reset("abort");
        chk("abort.count", int'(cnt_o[0]), 0);
        chk("abort.state", int'(st_o[0]), 0);
        chk("abort.done", int'(done_o[0]), 0);
        tick("abort_clk");
        reset = 1'b1;
        enable = 1'b0;
        tick("abort_release");

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            enable     = ($urandom_range(0, 3) != 0);
            load       = ($urandom_range(0, 15) == 0);
            load_value = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) up_down = ~up_down;
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rnd_rst");
                tick("rnd_rst_clk");
                reset = 1'b1;
            end else begin
                tick("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sat_updown_counter.md
SAT_UPDOWN_COUNTER -- requirements
Module: sat_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter MAX_VALUE, default 2**WIDTH-1: upper count limit, legal range 1..2**WIDTH-1.
REQ-003 Parameter RECYCLE, default 0: 0 means saturate at the limits (non-recycling), 1 means wrap around.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port enable, input, 1 bit: count one step this cycle.
REQ-007 Port up_down, input, 1 bit: direction, 1 means up, 0 means down.
REQ-008 Port load, input, 1 bit: synchronous load of load_value.
REQ-009 Port load_value, input, WIDTH bits: value to load.
REQ-010 Port count, output, WIDTH bits: current count (registered).
REQ-011 Port terminal, output, 1 bit: high while count sits at the limit in the current direction (MAX_VALUE when up, 0 when down).
REQ-012 Port done, output, 1 bit: one-cycle pulse when the counter first reaches the limit or wraps.
REQ-013 Port state, output, 2 bits: FSM state, for debug.

Function
REQ-014 The FSM shall have three states: IDLE=2'b00, RUN=2'b01, HELD=2'b10; 2'b11 is illegal and shall recover to IDLE on the next clock.
REQ-015 Priority shall be load > enable; load with enable high performs only the load.
REQ-016 A load shall set count = min(load_value, MAX_VALUE) on the next edge, and the state shall become RUN, or HELD if the loaded value equals the limit for the current up_down.
REQ-017 From IDLE or RUN, enable=1 shall step count by ±1 on the next edge (latency 1), and the state shall be RUN.
REQ-018 If RECYCLE=0 and a step would pass the limit, count shall hold at the limit, the state shall go to HELD, and done shall pulse for exactly one cycle on entry.
REQ-019 If RECYCLE=1, up from MAX_VALUE shall go to 0 and down from 0 shall go to MAX_VALUE; done shall pulse on each wrap, and HELD is never entered.
REQ-020 In HELD, enable in the same direction shall have no effect, with no further done pulse.
REQ-021 In HELD, enable with the opposite direction shall step away from the limit and return to RUN.
REQ-022 enable=0 and load=0 shall hold count and state.
REQ-023 terminal shall be combinational from count and up_down; done shall be registered and aligned with the count edge that reaches the limit.
REQ-024 Arithmetic shall be unsigned, WIDTH bits, with no overflow visible on count.
REQ-025 A direction change in the same cycle as enable shall use the new up_down value.

Reset
REQ-026 While reset=0: count=0, state=IDLE, done=0, asynchronously; terminal follows count=0 and up_down.
REQ-027 Reset asserted mid-count shall abort immediately, with no done pulse.
REQ-028 Release of reset shall be synchronised externally; the block shall take no action in the first edge after release unless enable or load is high.

Structure
REQ-029 State encodings and WIDTH-independent constants shall live in shared header counter_defs.vh, reused by later timer blocks.
REQ-030 The block shall be a single module with no sub-module; the next-count logic shall be one combinational always block, with separate sequential always blocks for count, state and done.

Verification
REQ-031 WIDTH=4, RECYCLE=0, hold up and enable 20 cycles from reset -> count 0..15, done high one cycle at count 15, state HELD, count remains 15.
REQ-032 From HELD at 15, set up_down=0 with enable -> count 14, state RUN, terminal=0.
REQ-033 RECYCLE=1, MAX_VALUE=9, count up from 8 -> 9 then 0, done pulses on the 9->0 edge, state stays RUN.
REQ-034 load=1, enable=1, load_value=13 with MAX_VALUE=11 -> count 11 next edge, state HELD (up), no step applied.
REQ-035 Drive reset=0 asynchronously at count 6, between clock edges -> count 0 and state IDLE before the next edge, done stays 0.
REQ-036 Down count from 2 with RECYCLE=0 -> 1, then 0 with done pulse, then held at 0 with terminal=1.
